// File: rtl/op_queue_mem.sv
`default_nettype none
// ============================================================================
// op_queue_mem : in-order operation queue with FWFT read port, flush and a
//                sticky overflow flag for the matrix execution engine.
// Revision     : 1.0
// ============================================================================
module op_queue_mem #(
    parameter int OP_WIDTH = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                wr_valid,
    input  logic [OP_WIDTH-1:0] wr_op,
    output logic                wr_ready,
    output logic                rd_valid,
    output logic [OP_WIDTH-1:0] rd_op,
    input  logic                rd_ready,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty,
    output logic                ovf_err
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [OP_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                wr_fire;
    logic                rd_fire;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign rd_valid = !empty;

    // Head word falls straight through; zero is presented while nothing is queued.
    assign rd_op    = empty ? '0 : mem[rd_ptr];

    assign wr_fire  = wr_valid && wr_ready && !flush;
    assign rd_fire  = rd_ready && rd_valid && !flush;

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (wr_valid && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_op_queue_mem.sv
`default_nettype none
// ============================================================================
// tb_op_queue_mem : directed and randomized checks of op_queue_mem against a
//                   queue-based reference model.
// Revision        : 1.0
// ============================================================================
module tb_op_queue_mem;

    localparam int OP_WIDTH = 16;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic                wr_valid;
    logic [OP_WIDTH-1:0] wr_op;
    logic                wr_ready;
    logic                rd_valid;
    logic [OP_WIDTH-1:0] rd_op;
    logic                rd_ready;
    logic [ADDR_W:0]     count;
    logic                full;
    logic                empty;
    logic                ovf_err;

    int errors = 0;
    int checks = 0;

    logic [OP_WIDTH-1:0] model_q[$];
    logic                model_ovf;

    op_queue_mem #(
        .OP_WIDTH(OP_WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_valid(wr_valid),
        .wr_op   (wr_op),
        .wr_ready(wr_ready),
        .rd_valid(rd_valid),
        .rd_op   (rd_op),
        .rd_ready(rd_ready),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".count"},    32'(count),    32'(n));
        check({tag, ".empty"},    32'(empty),    32'(n == 0));
        check({tag, ".full"},     32'(full),     32'(n == DEPTH));
        check({tag, ".wr_ready"}, 32'(wr_ready), 32'(n != DEPTH));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
        check({tag, ".rd_op"},    32'(rd_op),    (n == 0) ? 32'h0 : 32'(model_q[0]));
        check({tag, ".ovf_err"},  32'(ovf_err),  32'(model_ovf));
    endtask

    // Reference behaviour of one clock edge, from the inputs held across it.
    task automatic model_edge();
        int n;
        n = model_q.size();
        if (flush) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (wr_valid && n == DEPTH) model_ovf = 1'b1;
            if (rd_ready && n > 0) void'(model_q.pop_front());
            if (wr_valid && n < DEPTH) model_q.push_back(wr_op);
        end
    endtask

    task automatic drive(input logic f, input logic wv, input logic [OP_WIDTH-1:0] op, input logic rr);
        flush    = f;
        wr_valid = wv;
        wr_op    = op;
        rd_ready = rr;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        model_q.delete();
        model_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_outputs("reset");

        // Fill with 0x1000..0x1007
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b0);
            step("fill");
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        check("fill_full", 32'(full), 32'h1);
        check("fill_head", 32'(rd_op), 32'h1000);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 32'(rd_op), 32'h1000 + i);
            drive(1'b0, 1'b0, '0, 1'b1);
            step("drain");
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        check("drain_empty", 32'(empty), 32'h1);

        // Pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 16'h0A00 + 16'(i), 1'b0);
            step("wrap_w");
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            step("wrap_r");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0);
            step("wrap_w2");
        end
        for (int i = 0; i < 5; i++) begin
            check("wrap_order", 32'(rd_op), 32'h2000 + i);
            drive(1'b0, 1'b0, '0, 1'b1);
            step("wrap_r2");
        end

        // Simultaneous read/write at count=3
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'h0B00 + 16'(i), 1'b0);
            step("sim_pre");
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 16'h3000 + 16'(i), 1'b1);
            step("sim_rw");
            check("sim_count", 32'(count), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            step("sim_drain");
        end

        // Overflow on full with concurrent read, then flush
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 16'h4000 + 16'(i), 1'b0);
            step("ovf_fill");
        end
        drive(1'b0, 1'b1, 16'hDEAD, 1'b1);
        step("ovf_hit");
        check("ovf_count", 32'(count), 32'd7);
        check("ovf_flag", 32'(ovf_err), 32'h1);
        drive(1'b0, 1'b0, '0, 1'b0);
        step("ovf_hold");
        drive(1'b1, 1'b1, 16'hBEEF, 1'b1);
        step("flush");
        check("flush_ovf", 32'(ovf_err), 32'h0);

        // Asynchronous reset between edges at count=4
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 16'h5000 + 16'(i), 1'b0);
            step("ar_fill");
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        #2 reset = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        #1 check_outputs("async_reset");
        #2 reset = 1'b0;
        drive(1'b0, 1'b1, 16'h6000, 1'b0);
        step("ar_restart");
        drive(1'b0, 1'b0, '0, 1'b0);
        step("ar_idle");

        // Randomized traffic with varying write/read bias
        for (int phase = 0; phase < 6; phase++) begin
            int wp;
            int rp;
            wp = (phase % 3 == 0) ? 80 : (phase % 3 == 1) ? 50 : 25;
            rp = (phase % 3 == 0) ? 30 : (phase % 3 == 1) ? 50 : 80;
            for (int i = 0; i < 80; i++) begin
                drive($urandom_range(99) < 3,
                      $urandom_range(99) < wp,
                      OP_WIDTH'($urandom),
                      $urandom_range(99) < rp);
                step("rand");
            end
        end
        drive(1'b0, 1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
